// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the generic dual-port RAM and its read pipeline.
// Word/byte helpers work on a wide container so any DATA_W up to MAX_DATA_W fits.
package dp_ram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

  localparam int MAX_DATA_W = 1024;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  // Byte-enable width for a given word width.
  function automatic int calc_be_w(input int data_w);
    return data_w / 8;
  endfunction

  // Word count for a given address width.
  function automatic int calc_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Old word with every enabled byte replaced by the matching byte of the new word.
  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dp_ram_rdpipe.sv
// Read output pipeline: RD_LAT register stages of data and valid, no backpressure.
// Data stages only load on valid, so the output word holds between results.
module dp_ram_rdpipe #(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] dat_o
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [DATA_W-1:0] dat_q [RD_LAT];
  logic [DATA_W-1:0] dat_d [RD_LAT];

  always_comb begin
    vld_d = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      dat_d[i] = dat_q[i];
    end
    vld_d[0] = vld_i;
    if (vld_i) dat_d[0] = dat_i;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
    end
  end

  // Reset flushes every stage, so in-flight reads never surface.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q[RD_LAT-1];
  assign dat_o = dat_q[RD_LAT-1];

endmodule

// File: rtl/dp_ram_gen.sv
// Simple dual-port RAM (1W/1R, one clock) with byte enables, RD_LAT 1/2 read latency,
// selectable collision mode and a one-word-per-cycle clear engine; requests dropped while busy.
module dp_ram_gen
  import dp_ram_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 8,
  parameter int RD_LAT       = 1,
  parameter int BYPASS       = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                busy
);

  localparam int BE_W  = calc_be_w(DATA_W);
  localparam int DEPTH = calc_depth(ADDR_W);
  localparam clr_state_e RST_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_acc;
  logic              rd_acc;
  logic              collide;
  logic [DATA_W-1:0] rd_word;

  assign busy    = (state_q == ST_CLEAR);
  assign wr_acc  = wr_en & ~busy;
  assign rd_acc  = rd_en & ~busy;
  assign collide = wr_acc & rd_acc & (wr_addr == rd_addr);

  // The counter parks on the last address when done; only reset returns it to zero.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_READY;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RST_STATE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Array has no reset; the clear engine owns the write port while busy.
  always_ff @(posedge clk) begin
    if (busy && !rst) begin
      mem_q[clr_addr_q] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Write-first mode forwards the enabled bytes of a same-address write.
  always_comb begin
    rd_word = mem_q[rd_addr];
    if ((BYPASS != 0) && collide) begin
      rd_word = DATA_W'(byte_merge(MAX_DATA_W'(mem_q[rd_addr]),
                                   MAX_DATA_W'(wr_data),
                                   MAX_BE_W'(wr_be)));
    end
  end

  dp_ram_rdpipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk   (clk),
    .rst   (rst),
    .vld_i (rd_acc),
    .dat_i (rd_word),
    .vld_o (rd_valid),
    .dat_o (rd_data)
  );

endmodule

// File: tb/tb_dp_ram_gen.sv
// Bench for dp_ram_gen: instance 0 uses defaults, instance 1 is RD_LAT=2, read-first, no clear.
module tb_dp_ram_gen;

  typedef struct {
    logic [15:0] data;
    int          due;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en   [2];
  logic [7:0]  wr_addr [2];
  logic [15:0] wr_data [2];
  logic [1:0]  wr_be   [2];
  logic        rd_en   [2];
  logic [7:0]  rd_addr [2];
  logic [15:0] rd_data [2];
  logic        rd_valid[2];
  logic        busy    [2];

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  sb_t q0[$];
  sb_t q1[$];
  sb_t e0, e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dp_ram_gen u0 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_be(wr_be[0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
    .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .busy(busy[0])
  );

  dp_ram_gen #(.DATA_W(16), .ADDR_W(8), .RD_LAT(2), .BYPASS(0), .CLEAR_ON_RST(0)) u1 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_be(wr_be[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]),
    .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .busy(busy[1])
  );

  // Scoreboards: every rd_valid must match the oldest expectation, data and cycle.
  always @(negedge clk) begin
    if (rd_valid[0] === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL u0_unexpected_valid: rd_data=%h at cyc %0d, no read outstanding", rd_data[0], cyc);
      end else begin
        e0 = q0.pop_front();
        if (rd_data[0] !== e0.data || cyc != e0.due) begin
          errors++;
          $display("FAIL u0_read: got %h at cyc %0d, expected %h at cyc %0d", rd_data[0], cyc, e0.data, e0.due);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rd_valid[1] === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL u1_unexpected_valid: rd_data=%h at cyc %0d, no read outstanding", rd_data[1], cyc);
      end else begin
        e1 = q1.pop_front();
        if (rd_data[1] !== e1.data || cyc != e1.due) begin
          errors++;
          $display("FAIL u1_read: got %h at cyc %0d, expected %h at cyc %0d", rd_data[1], cyc, e1.data, e1.due);
        end
      end
    end
  end

  // One cycle of stimulus on instance s; an expected read result is queued with its due cycle.
  task automatic op(input int s, input bit we, input logic [7:0] wa, input logic [15:0] wd,
                    input logic [1:0] be, input bit re, input logic [7:0] ra, input logic [15:0] exp);
    wr_en[s] = we; wr_addr[s] = wa; wr_data[s] = wd; wr_be[s] = be;
    rd_en[s] = re; rd_addr[s] = ra;
    if (re) begin
      if (s == 0) q0.push_back('{exp, cyc + 1});
      else        q1.push_back('{exp, cyc + 2});
    end
    @(posedge clk); #1;
    wr_en[s] = 1'b0; rd_en[s] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 10; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy[0] === 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy[0] !== 1'b1)      begin errors++; $display("FAIL reset_busy0: got %b, expected 1", busy[0]); end
    checks++; if (busy[1] !== 1'b0)      begin errors++; $display("FAIL reset_busy1: got %b, expected 0", busy[1]); end
    checks++; if (rd_valid[0] !== 1'b0)  begin errors++; $display("FAIL reset_valid0: got %b, expected 0", rd_valid[0]); end
    checks++; if (rd_valid[1] !== 1'b0)  begin errors++; $display("FAIL reset_valid1: got %b, expected 0", rd_valid[1]); end
    checks++; if (rd_data[0] !== 16'h0)  begin errors++; $display("FAIL reset_data0: got %h, expected 0000", rd_data[0]); end
    checks++; if (rd_data[1] !== 16'h0)  begin errors++; $display("FAIL reset_data1: got %h, expected 0000", rd_data[1]); end
    rst = 1'b0;
    count_busy(n);
    checks++; if (n != 256) begin errors++; $display("FAIL clear_busy_cycles: got %0d, expected 256", n); end
    checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL noclear_busy: got %b, expected 0", busy[1]); end
  endtask

  task automatic test_clear_reads();
    op(0, 0, 8'h00, 16'h0, 2'b00, 1, 8'h00, 16'h0000);
    op(0, 0, 8'h00, 16'h0, 2'b00, 1, 8'h7F, 16'h0000);
    op(0, 0, 8'h00, 16'h0, 2'b00, 1, 8'hFF, 16'h0000);
    wait_drain();
  endtask

  task automatic test_byte_enable();
    for (int s = 0; s < 2; s++) begin
      op(s, 1, 8'h10, 16'hABCD, 2'b11, 0, 8'h00, 16'h0);
      op(s, 1, 8'h10, 16'h1234, 2'b01, 0, 8'h00, 16'h0);
      op(s, 1, 8'h10, 16'hFFFF, 2'b00, 0, 8'h00, 16'h0);
      op(s, 0, 8'h00, 16'h0,    2'b00, 1, 8'h10, 16'hAB34);
    end
    wait_drain();
  endtask

  task automatic test_collision();
    for (int s = 0; s < 2; s++) begin
      op(s, 1, 8'h20, 16'h1111, 2'b11, 0, 8'h00, 16'h0);
      op(s, 1, 8'h20, 16'h2222, 2'b10, 1, 8'h20, (s == 0) ? 16'h2211 : 16'h1111);
      op(s, 1, 8'h21, 16'h3333, 2'b11, 1, 8'h20, 16'h2211);
      op(s, 0, 8'h00, 16'h0,    2'b00, 1, 8'h21, 16'h3333);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    op(1, 1, 8'h01, 16'h0001, 2'b11, 0, 8'h00, 16'h0);
    op(1, 1, 8'h02, 16'h0002, 2'b11, 0, 8'h00, 16'h0);
    op(1, 1, 8'h03, 16'h0003, 2'b11, 0, 8'h00, 16'h0);
    op(1, 0, 8'h00, 16'h0,    2'b00, 1, 8'h01, 16'h0001);
    op(1, 0, 8'h00, 16'h0,    2'b00, 1, 8'h02, 16'h0002);
    op(1, 0, 8'h00, 16'h0,    2'b00, 1, 8'h03, 16'h0003);
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (q1.size() != 0)        begin errors++; $display("FAIL b2b_drain: %0d reads outstanding, expected 0", q1.size()); end
    checks++; if (rd_data[1] !== 16'h3)  begin errors++; $display("FAIL b2b_hold: got %h, expected 0003", rd_data[1]); end
    checks++; if (rd_valid[1] !== 1'b0)  begin errors++; $display("FAIL b2b_valid_idle: got %b, expected 0", rd_valid[1]); end
  endtask

  task automatic test_no_clear();
    int seen;
    int n;
    rd_en[1] = 1'b1; rd_addr[1] = 8'h03;
    @(posedge clk); #1;
    rd_en[1] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy[1] !== 1'b0)     begin errors++; $display("FAIL noclear_busy_after_rst: got %b, expected 0", busy[1]); end
    checks++; if (rd_data[1] !== 16'h0) begin errors++; $display("FAIL inflight_rst_data: got %h, expected 0000", rd_data[1]); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rd_valid[1] === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL inflight_dropped: got %0d valids, expected 0", seen); end
    op(1, 1, 8'hFF, 16'h5A5A, 2'b11, 0, 8'h00, 16'h0);
    op(1, 0, 8'h00, 16'h0,    2'b00, 1, 8'hFF, 16'h5A5A);
    wait_drain();
    count_busy(n);
  endtask

  task automatic test_mid_clear();
    int n;
    op(0, 1, 8'h7F, 16'hBEEF, 2'b11, 0, 8'h00, 16'h0);
    op(0, 1, 8'hFF, 16'hCAFE, 2'b11, 0, 8'h00, 16'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    while (busy[0] === 1'b1 && n < 1000) begin
      wr_en[0] = (n == 200); wr_addr[0] = 8'h05; wr_data[0] = 16'hFFFF; wr_be[0] = 2'b11;
      rd_en[0] = (n == 200); rd_addr[0] = 8'h05;
      @(posedge clk); #1;
      n++;
    end
    wr_en[0] = 1'b0; rd_en[0] = 1'b0;
    checks++; if (n != 256) begin errors++; $display("FAIL midclear_busy_cycles: got %0d, expected 256", n); end
    op(0, 0, 8'h00, 16'h0, 2'b00, 1, 8'h05, 16'h0000);
    op(0, 0, 8'h00, 16'h0, 2'b00, 1, 8'h7F, 16'h0000);
    op(0, 0, 8'h00, 16'h0, 2'b00, 1, 8'hFF, 16'h0000);
    wait_drain();
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      wr_en[s] = 1'b0; wr_addr[s] = '0; wr_data[s] = '0; wr_be[s] = '0;
      rd_en[s] = 1'b0; rd_addr[s] = '0;
    end
    test_reset();
    test_clear_reads();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_no_clear();
    test_mid_clear();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL final_drain: %0d/%0d reads outstanding, expected 0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_ram_gen.md
Name: dp_ram_gen

Overview:
Parametrised simple dual-port synchronous RAM with one write port and one read port on a single clock. Successor to the fixed 256x16 dual-port RAM. Adds byte-enabled writes, configurable read latency, read-valid tracking and selectable read/write collision mode. Memory is cleared by a sequential engine after reset, one word per cycle, instead of a single-cycle clear of the whole array. Used as a generic buffer and lookup store by datapath blocks.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of 8
ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
RD_LAT, 1, read latency in cycles; legal values 1 or 2
BYPASS, 1, 1 = write-first (new data) on same-address collision; 0 = read-first (old data)
CLEAR_ON_RST, 1, 1 = zero the whole array after reset; 0 = skip clear, contents undefined

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
wr_en  in  1  write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_be  in  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i]
rd_en  in  1  read request
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  read data; holds last value when no new read completes
rd_valid  out  1  one-cycle pulse, RD_LAT cycles after an accepted rd_en
busy  out  1  clear engine active; all requests ignored while high

Behaviour:
- Reset values: rd_data = 0, rd_valid = 0, read pipeline valid bits = 0, clear address counter = 0. busy = 1 if CLEAR_ON_RST, else 0.
- Clear FSM has two states, CLEAR and READY.
  - rst enters CLEAR if CLEAR_ON_RST, otherwise READY.
  - In CLEAR: write 0 to mem[clr_addr], then increment clr_addr. After writing DEPTH-1, move to READY.
  - CLEAR lasts exactly DEPTH cycles after rst deasserts. busy is high for all of those cycles and low from the next cycle on.
  - rst asserted mid-clear restarts the clear from address 0.
- While busy, wr_en and rd_en are ignored: no write happens and no rd_valid is produced.
- Accepted write: wr_en high and busy low. Byte i of mem[wr_addr] is updated only if wr_be[i] is high. wr_en with wr_be all zero changes nothing.
- Accepted read: rd_en high and busy low. The array is sampled at that edge.
  - RD_LAT=1: rd_data and rd_valid update on the next edge.
  - RD_LAT=2: one extra output register stage is added; rd_data and rd_valid update one edge later.
  - Back-to-back reads give one result per cycle, returned in request order.
- Collision (accepted write and accepted read to the same address in the same cycle):
  - BYPASS=1: the returned word is the old word with the enabled bytes replaced by wr_data bytes.
  - BYPASS=0: the returned word is the old word.
  - In both modes the array is updated normally.
- Reads of different addresses are unaffected by a concurrent write.
- Addresses cover the full range 0..DEPTH-1; out-of-range cannot occur. clr_addr wraps to 0 only through reset.
- rd_data does not change while rd_valid is low, except through reset.
- rst during an in-flight read drops the read: no rd_valid is produced for it.

Decomposition:
- Shared package dp_ram_pkg holds:
  - clear-FSM state enum (CLEAR, READY)
  - function byte_merge(old, new, be) returning the byte-masked word
  - localparam helpers BE_W = DATA_W/8 and DEPTH = 1<<ADDR_W
- One sub-module: dp_ram_rdpipe, the parametrised read output pipeline (RD_LAT stages of data and valid).
- The array, write logic and clear FSM stay in the top module.

Test Plan:
- Clear after reset (defaults): pulse rst 1 cycle → busy high exactly 256 cycles; then reads of addr 0, 0x7F and 0xFF each return 0x0000 with one rd_valid pulse.
- Byte-enabled write: write 0xABCD to addr 0x10 with be=2'b11, then 0x1234 with be=2'b01 → read addr 0x10 returns 0xAB34.
- Collision: addr 0x20 holds 0x1111; same cycle write 0x2222 (be=2'b10) and read addr 0x20 → BYPASS=1 returns 0x2211, BYPASS=0 returns 0x1111. A later read returns 0x2211 in both modes.
- Latency and throughput with RD_LAT=2: reads of addr 1, 2, 3 on consecutive cycles (preloaded 0x0001/0x0002/0x0003) → rd_valid high on cycles t+2, t+3, t+4 with data in order. rd_data holds 0x0003 afterwards.
- Reset mid-clear: assert rst at clear cycle 100 → busy stays high a further 256 cycles from deassert. A write issued during busy to addr 5 with 0xFFFF is dropped, and addr 5 reads 0x0000.
- CLEAR_ON_RST=0: busy is 0 immediately after reset, and a write then read of addr 0xFF with 0x5A5A returns 0x5A5A after RD_LAT cycles.
